// File: rtl/hex_draw_pkg.sv
// Shared constants for the hex value drawer: 8x8 glyph font, default colours,
// default screen size and the draw FSM state type.
package hex_draw_pkg;

    localparam logic [8:0]  DEF_FG       = 9'h1FF;
    localparam logic [8:0]  DEF_BG       = 9'h000;
    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } draw_state_t;

    // Row 0 is the top of the cell and bit 7 is its leftmost pixel; row 7 is blank spacing.
    localparam logic [7:0] GLYPHS [16][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h66, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00},
        '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
        '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h7E, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h60, 8'h00}
    };

endpackage

// File: rtl/hex_font_rom.sv
// Combinational glyph lookup: one 8-pixel row of the hex digit glyph.
module hex_font_rom
    import hex_draw_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    assign bits = GLYPHS[nibble][row];

endmodule

// File: rtl/hex_value_drawer.sv
// Draws a latched 32-bit value as eight 8x8 hex glyphs (64x8 field) into the
// VGA pixel-write path, one pixel per cycle, then pulses done.
module hex_value_drawer
    import hex_draw_pkg::*;
#(
    parameter int                 X_W      = 8,
    parameter int                 Y_W      = 7,
    parameter int                 COLOR_W  = 9,
    parameter int unsigned        SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned        SCREEN_H = DEF_SCREEN_H,
    parameter logic [COLOR_W-1:0] FG       = COLOR_W'(DEF_FG),
    parameter logic [COLOR_W-1:0] BG       = COLOR_W'(DEF_BG)
)(
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic [31:0]        value,
    input  logic [X_W-1:0]     origin_x,
    input  logic [Y_W-1:0]     origin_y,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] colour,
    output logic               plot
);

    draw_state_t        r_state;
    draw_state_t        w_nextState;

    logic [8:0]         r_pc;
    logic [31:0]        r_value;
    logic [X_W-1:0]     r_originX;
    logic [Y_W-1:0]     r_originY;

    logic               r_busy;
    logic               r_done;
    logic               r_plot;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COLOR_W-1:0] r_colour;

    logic [2:0]         w_digit;
    logic [2:0]         w_row;
    logic [2:0]         w_col;
    logic [3:0]         w_nibble;
    logic [7:0]         w_glyphRow;
    logic [X_W-1:0]     w_x;
    logic [Y_W-1:0]     w_y;
    logic               w_pixelOn;
    logic               w_onScreen;
    logic               w_accept;

    assign w_digit  = r_pc[8:6];
    assign w_row    = r_pc[5:3];
    assign w_col    = r_pc[2:0];
    assign w_accept = (r_state == IDLE) && start;

    // Digit 0 is the top nibble so the value reads left to right.
    assign w_nibble = r_value[{~w_digit, 2'b00} +: 4];

    hex_font_rom u_fontRom (
        .nibble (w_nibble),
        .row    (w_row),
        .bits   (w_glyphRow)
    );

    assign w_x        = r_originX + X_W'({w_digit, w_col});
    assign w_y        = r_originY + Y_W'(w_row);
    assign w_pixelOn  = w_glyphRow[~w_col];
    assign w_onScreen = (32'(w_x) < SCREEN_W) && (32'(w_y) < SCREEN_H);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = DRAW;
            DRAW:    if (r_pc == 9'd511) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Status and pixel outputs trail the state by one edge, so they describe the pixel just issued.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= '0;
            r_value   <= '0;
            r_originX <= '0;
            r_originY <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_plot    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= BG;
        end else begin
            r_busy <= (r_state == DRAW);
            r_done <= (r_state == DONE);
            r_plot <= (r_state == DRAW) && w_onScreen;

            if (w_accept) begin
                r_value   <= value;
                r_originX <= origin_x;
                r_originY <= origin_y;
                r_pc      <= '0;
            end else if (r_state == DRAW) begin
                r_pc <= r_pc + 9'd1;
            end

            if (r_state == DRAW) begin
                r_x      <= w_x;
                r_y      <= w_y;
                r_colour <= w_pixelOn ? FG : BG;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign plot   = r_plot;
    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;

endmodule
